// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first, registered borrow.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to build the two's-complement overflow flag.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_START,
  input  logic [WIDTH-1:0] i_MINUEND,
  input  logic [WIDTH-1:0] i_SUBTRAHEND,
  input  logic             i_BORROW_IN,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic [WIDTH-1:0] o_DIFFERENCE,
  output logic             o_BORROW_OUT,
  output logic             o_OVERFLOW
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             borrow_d;
  logic             borrowOut_q;
  logic             busy_q;
  logic             done_q;
  logic             bitA;
  logic             bitB;
  logic             diffBit;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             aMsb_q;
  logic             bMsb_q;
  logic             ovf_q;
`endif

  // Full-subtractor cell; the new bit enters the result from the top so bit 0 lands at the LSB.
  assign bitA     = aShift_q[0];
  assign bitB     = bShift_q[0];
  assign diffBit  = bitA ^ bitB ^ borrow_q;
  assign borrow_d = (~bitA & bitB) | (~(bitA ^ bitB) & borrow_q);
  assign res_d    = {diffBit, res_q[WIDTH-1:1]};

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q     <= IDLE;
      aShift_q    <= '0;
      bShift_q    <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      borrowOut_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      aMsb_q      <= 1'b0;
      bMsb_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a start exactly like IDLE so back-to-back operations lose no cycle.
        IDLE, DONE: begin
          if (i_START) begin
            state_q  <= SHIFT;
            aShift_q <= i_MINUEND;
            bShift_q <= i_SUBTRAHEND;
            res_q    <= '0;
            borrow_q <= i_BORROW_IN;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            aMsb_q   <= i_MINUEND[WIDTH-1];
            bMsb_q   <= i_SUBTRAHEND[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          aShift_q <= aShift_q >> 1;
          bShift_q <= bShift_q >> 1;
          res_q    <= res_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            diff_q      <= res_d;
            borrowOut_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            ovf_q       <= (aMsb_q ^ bMsb_q) & (aMsb_q ^ diffBit);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_BUSY       = busy_q;
  assign o_DONE       = done_q;
  assign o_DIFFERENCE = diff_q;
  assign o_BORROW_OUT = borrowOut_q;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign o_OVERFLOW = ovf_q;
`else
  assign o_OVERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor with a queue-based result scoreboard.
// Honours SERIAL_SUBTRACTOR_OVERFLOW_EN when predicting the overflow flag.
module tb_serial_subtractor;

  localparam int WIDTH   = 8;
  localparam int LATENCY = WIDTH + 1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             borrowIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrowOut;
  logic             overflow;

  exp_t sbQ[$];
  int   total      = 0;
  int   bad        = 0;
  int   startCount = 0;
  int   doneCount  = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .i_CLK        (clock),
    .i_RESET      (reset),
    .i_START      (start),
    .i_MINUEND    (minuend),
    .i_SUBTRAHEND (subtrahend),
    .i_BORROW_IN  (borrowIn),
    .o_BUSY       (busy),
    .o_DONE       (done),
    .o_DIFFERENCE (difference),
    .o_BORROW_OUT (borrowOut),
    .o_OVERFLOW   (overflow)
  );

  always #5 clock = ~clock;

  // Reference: unsigned subtraction one bit wider than the operands gives the borrow in the top bit.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    logic [WIDTH:0] r;
    exp_t           e;
    r      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    e.diff = r[WIDTH-1:0];
    e.bout = r[WIDTH];
    e.ovf  = OVF_EN & (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ r[WIDTH-1]);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a start between edges; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic bin, input bit track);
    start      = 1'b1;
    minuend    = a;
    subtrahend = b;
    borrowIn   = bin;
    if (track) begin
      sbQ.push_back(model(a, b, bin));
      startCount++;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (n < 4 * LATENCY) begin
      @(negedge clock);
      n++;
      if (done) break;
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding start.
  always @(negedge clock) begin
    if (done) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("sb_diff", 32'(difference), 32'(e.diff));
        checkOutput("sb_borrow", 32'(borrowOut), 32'(e.bout));
        checkOutput("sb_overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int extraDone;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rbin;

    reset      = 1'b1;
    start      = 1'b0;
    minuend    = '0;
    subtrahend = '0;
    borrowIn   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_diff", 32'(difference), 32'd0);
    checkOutput("rst_borrow", 32'(borrowOut), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Basic operation and latency
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    n = 1;
    if (!done) begin
      waitDone(extraDone);
      n = n + extraDone;
    end
    checkOutput("latency_5a", 32'(n), 32'(LATENCY));
    checkOutput("diff_5a", 32'(difference), 32'h1E);
    checkOutput("borrow_5a", 32'(borrowOut), 32'd0);
    checkOutput("busy_in_done", 32'(busy), 32'd0);

    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1);
    waitDone(n);
    checkOutput("latency_10", 32'(n), 32'(LATENCY));
    checkOutput("diff_10", 32'(difference), 32'hF0);
    checkOutput("borrow_10", 32'(borrowOut), 32'd1);

    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    waitDone(n);
    checkOutput("diff_00", 32'(difference), 32'hFF);
    checkOutput("borrow_00", 32'(borrowOut), 32'd1);

    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
    waitDone(n);
    checkOutput("diff_80", 32'(difference), 32'h7F);
    checkOutput("borrow_80", 32'(borrowOut), 32'd0);
    checkOutput("overflow_80", 32'(overflow), 32'(OVF_EN));

    // Start while busy must be ignored
    applyStimulus(8'h33, 8'h11, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    start      = 1'b1;
    minuend    = 8'hFF;
    subtrahend = 8'hFF;
    @(posedge clock);
    #1;
    start = 1'b0;
    waitDone(n);
    checkOutput("latency_33", 32'(n), 32'(LATENCY - 3));
    checkOutput("diff_33", 32'(difference), 32'h22);

    // Back-to-back start in the DONE cycle; previous result must hold
    applyStimulus(8'h05, 8'h07, 1'b0, 1'b1);
    checkOutput("b2b_done_low", 32'(done), 32'd0);
    checkOutput("b2b_busy_high", 32'(busy), 32'd1);
    checkOutput("b2b_hold_diff", 32'(difference), 32'h22);
    waitDone(n);
    checkOutput("latency_b2b", 32'(n), 32'(LATENCY));
    checkOutput("diff_05", 32'(difference), 32'hFE);
    checkOutput("borrow_05", 32'(borrowOut), 32'd1);

    // Reset mid-operation aborts without a done pulse
    applyStimulus(8'h44, 8'h11, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_diff", 32'(difference), 32'd0);
    checkOutput("abort_borrow", 32'(borrowOut), 32'd0);
    reset = 1'b0;
    extraDone = 0;
    repeat (2 * LATENCY) begin
      @(negedge clock);
      if (done) extraDone++;
    end
    checkOutput("abort_no_done", 32'(extraDone), 32'd0);

    // Reset wins over a simultaneous start
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("rst_prio_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);

    applyStimulus(8'h9C, 8'h4B, 1'b1, 1'b1);
    waitDone(n);
    checkOutput("latency_fresh", 32'(n), 32'(LATENCY));
    checkOutput("diff_fresh", 32'(difference), 32'h50);

    // Random back-to-back traffic checked by the scoreboard
    for (int i = 0; i < 1000; i++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rbin = 1'($urandom_range(1, 0));
      applyStimulus(ra, rb, rbin, 1'b1);
      waitDone(n);
      checkOutput("latency_rand", 32'(n), 32'(LATENCY));
    end

    repeat (3) @(negedge clock);
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("done_per_start", 32'(doneCount), 32'(startCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
